// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared definitions for the PC generator
package pc_gen_pkg;

  localparam logic [31:0] INIT_32        = 32'h0000_0000;
  localparam logic [31:0] RESET_VEC_DEF  = INIT_32;
  localparam int          INST_BYTES_DEF = 4;

  // Thread-id width; a single thread still gets a one-bit id port.
  function automatic int tid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_gen_rr_pick.sv
// rtl/pc_gen_rr_pick.sv - first requester at or after a pointer, wrapping
module rr_pick
  import pc_gen_pkg::*;
#(
  parameter int N = 2,
  localparam int W = tid_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [2*N-1:0] rot;

  always_comb begin
    int k;
    k     = 0;
    found = 1'b0;
    idx   = '0;
    // Rotating a doubled copy puts the pointer position at bit 0.
    rot   = {req, req} >> ptr;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        k     = int'(ptr) + i;
        if (k >= N) k = k - N;
        idx   = W'(k);
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - multithreaded PC generator with round-robin fetch select
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               XLEN       = 32,
  parameter int               NTHREAD    = 2,
  parameter logic [XLEN-1:0]  RESET_VEC  = XLEN'(RESET_VEC_DEF),
  parameter int               INST_BYTES = INST_BYTES_DEF,
  localparam int              TW         = tid_w(NTHREAD)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NTHREAD-1:0] thread_en,
  input  logic               stall,
  input  logic               flush_valid,
  input  logic [TW-1:0]      flush_tid,
  input  logic               redir_valid,
  input  logic [TW-1:0]      redir_tid,
  input  logic [XLEN-1:0]    redir_pc,
  output logic               fetch_valid,
  output logic [TW-1:0]      fetch_tid,
  output logic [XLEN-1:0]    fetch_pc,
  output logic               misalign
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INST_BYTES - 1);
  localparam logic [XLEN-1:0] STEP     = XLEN'(INST_BYTES);

  logic [XLEN-1:0] pc_q [NTHREAD];
  logic [XLEN-1:0] pc_d [NTHREAD];
  logic [TW-1:0]   rr_q;
  logic [TW-1:0]   sel;
  logic            sel_found;
  logic [XLEN-1:0] sel_pc;
  logic [TW-1:0]   rr_next;
  logic            flush_ok, redir_ok, redir_acc;
  logic            sel_hit, hold_hit, fetch_go;

  rr_pick #(.N(NTHREAD)) u_pick (
    .req   (thread_en),
    .ptr   (rr_q),
    .found (sel_found),
    .idx   (sel)
  );

  assign flush_ok  = flush_valid && (int'(flush_tid) < NTHREAD);
  assign redir_ok  = redir_valid && (int'(redir_tid) < NTHREAD);
  assign redir_acc = redir_ok && !(flush_ok && flush_tid == redir_tid);

  // A thread being retargeted this cycle must not also issue its stale PC.
  assign sel_hit  = (flush_ok && flush_tid == sel) || (redir_ok && redir_tid == sel);
  assign hold_hit = (flush_ok && flush_tid == fetch_tid) || (redir_ok && redir_tid == fetch_tid);
  assign fetch_go = !stall && sel_found && !sel_hit;
  assign rr_next  = (int'(sel) == NTHREAD - 1) ? '0 : sel + TW'(1);

  always_comb begin
    sel_pc = RESET_VEC;
    for (int t = 0; t < NTHREAD; t++) begin
      if (int'(sel) == t) sel_pc = pc_q[t];
    end
  end

  always_comb begin
    for (int t = 0; t < NTHREAD; t++) begin
      pc_d[t] = pc_q[t];
      if (flush_ok && int'(flush_tid) == t)
        pc_d[t] = RESET_VEC;
      else if (redir_acc && int'(redir_tid) == t)
        pc_d[t] = redir_pc & ~LOW_MASK;
      else if (fetch_go && int'(sel) == t)
        pc_d[t] = pc_q[t] + STEP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < NTHREAD; t++) pc_q[t] <= RESET_VEC;
      rr_q        <= '0;
      fetch_valid <= 1'b0;
      fetch_tid   <= '0;
      fetch_pc    <= RESET_VEC;
      misalign    <= 1'b0;
    end else begin
      for (int t = 0; t < NTHREAD; t++) pc_q[t] <= pc_d[t];
      misalign <= redir_acc && |(redir_pc & LOW_MASK);
      if (stall) begin
        if (hold_hit) fetch_valid <= 1'b0;
      end else if (fetch_go) begin
        fetch_valid <= 1'b1;
        fetch_tid   <= sel;
        fetch_pc    <= sel_pc;
        rr_q        <= rr_next;
      end else begin
        fetch_valid <= 1'b0;
      end
    end
  end

endmodule
